fibonacci_display_monitor: RTL and testbench

- Receive-side counterpart of the Fibonacci seven-segment display driver.
- Observes the three active-low digit buses (units, tens, hundreds) and debounces each displayed frame.
- Decodes segment patterns back to decimal digits and converts them to a binary value.
- Checks that successive values form the Fibonacci sequence; reports matches, mismatches and illegal frames for on-board self-test.

---
 rtl/fibonacci_display_monitor.sv | 251 +++++++++++++++++++++++++
 tb/tb_fibonacci_display_monitor.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fibonacci_display_monitor.sv
// Receive-side monitor for the Fibonacci seven-segment display driver.
// Debounces the three digit buses, decodes frames to a binary value and
// checks that successive values follow the Fibonacci sequence.
module fibonacci_display_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       hex0,
  input  logic [6:0]       hex1,
  input  logic [6:0]       hex2,
  output logic [9:0]       value,
  output logic             value_valid,
  output logic             seq_ok,
  output logic             seq_err,
  output logic             bad_frame,
  output logic             locked,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned FRAME_W = 21;
  localparam int unsigned STAB_W  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned VAL_W   = 10;
  localparam int unsigned SUM_W   = 11;

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_ACC = STAB_W'(STABLE_CYCLES - 1);

  localparam logic [3:0] DIG_DASH = 4'hA;
  localparam logic [3:0] DIG_ILL  = 4'hF;

  typedef enum logic [1:0] {
    CLS_NUM,
    CLS_BLANK,
    CLS_BAD
  } frame_cls_t;

  typedef enum logic [1:0] {
    SEEK,
    ONE,
    TRACK
  } chk_state_t;

  // Active-low segment pattern to digit code (DASH / ILLEGAL as escapes).
  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    logic [3:0] d;
    case (seg)
      7'b1000000: d = 4'd0;
      7'b1111001: d = 4'd1;
      7'b0100100: d = 4'd2;
      7'b0110000: d = 4'd3;
      7'b0011001: d = 4'd4;
      7'b0010010: d = 4'd5;
      7'b0000010: d = 4'd6;
      7'b1111000: d = 4'd7;
      7'b0000000: d = 4'd8;
      7'b0010000: d = 4'd9;
      7'b0111111: d = DIG_DASH;
      default:    d = DIG_ILL;
    endcase
    return d;
  endfunction

  logic [FRAME_W-1:0] frame_in_c;
  logic [FRAME_W-1:0] s_hex;
  logic [STAB_W-1:0]  stab_cnt;
  logic               accept_c;
  logic               acc_valid;
  logic               acc_stb;
  logic [FRAME_W-1:0] acc_frame;

  logic [3:0]         d0_c, d1_c, d2_c;
  frame_cls_t         cls_c;
  logic               dec_stb;
  logic [3:0]         dec_d0, dec_d1, dec_d2;
  frame_cls_t         dec_cls;
  logic               blank_evt;

  chk_state_t         state, state_next;
  logic [VAL_W-1:0]   prev, prev_next;
  logic [VAL_W-1:0]   cur, cur_next;
  logic               locked_next;
  logic               seq_ok_next;
  logic               seq_err_next;
  logic [SUM_W-1:0]   expected_c;

  assign frame_in_c = {hex2, hex1, hex0};

  // New frame only when stable long enough and different from the last accepted one.
  assign accept_c = (frame_in_c == s_hex) && (stab_cnt == STAB_ACC) &&
                    (!acc_valid || (s_hex != acc_frame));

  // Sample register and stability counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_hex    <= '1;
      stab_cnt <= '0;
    end else begin
      s_hex <= frame_in_c;
      if (frame_in_c != s_hex) begin
        stab_cnt <= '0;
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + STAB_W'(1);
      end
    end
  end

  // Accepted frame register; acc_frame doubles as the last accepted pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_valid <= 1'b0;
      acc_stb   <= 1'b0;
      acc_frame <= '0;
    end else begin
      acc_stb <= accept_c;
      if (accept_c) begin
        acc_valid <= 1'b1;
        acc_frame <= s_hex;
      end
    end
  end

  // Per-digit decode and frame classification.
  always_comb begin
    d0_c  = seg_decode(acc_frame[6:0]);
    d1_c  = seg_decode(acc_frame[13:7]);
    d2_c  = seg_decode(acc_frame[20:14]);
    cls_c = CLS_BAD;
    if ((d0_c < 4'd10) && (d1_c < 4'd10) && (d2_c < 4'd10)) begin
      cls_c = CLS_NUM;
    end else if (((d0_c == DIG_DASH) && (d1_c == DIG_DASH) && (d2_c == DIG_DASH)) ||
                 (acc_frame == '1)) begin
      cls_c = CLS_BLANK;
    end
  end

  // Decode stage register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_stb <= 1'b0;
      dec_d0  <= '0;
      dec_d1  <= '0;
      dec_d2  <= '0;
      dec_cls <= CLS_NUM;
    end else begin
      dec_stb <= acc_stb;
      dec_d0  <= d0_c;
      dec_d1  <= d1_c;
      dec_d2  <= d2_c;
      dec_cls <= cls_c;
    end
  end

  // Conversion stage: BCD to binary plus frame-type pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      value       <= '0;
      value_valid <= 1'b0;
      bad_frame   <= 1'b0;
      blank_evt   <= 1'b0;
    end else begin
      value_valid <= dec_stb && (dec_cls == CLS_NUM);
      bad_frame   <= dec_stb && (dec_cls == CLS_BAD);
      blank_evt   <= dec_stb && (dec_cls == CLS_BLANK);
      if (dec_stb && (dec_cls == CLS_NUM)) begin
        value <= VAL_W'(dec_d2) * VAL_W'(100) + VAL_W'(dec_d1) * VAL_W'(10) + VAL_W'(dec_d0);
      end
    end
  end

  // Fibonacci successor; the repeated 1 never shows, so (0,1) must be followed by 2.
  assign expected_c = ((prev == '0) && (cur == VAL_W'(1))) ? SUM_W'(2)
                                                          : SUM_W'(prev) + SUM_W'(cur);

  // Checker state register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SEEK;
      prev    <= '0;
      cur     <= '0;
      locked  <= 1'b0;
      seq_ok  <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      state   <= state_next;
      prev    <= prev_next;
      cur     <= cur_next;
      locked  <= locked_next;
      seq_ok  <= seq_ok_next;
      seq_err <= seq_err_next;
    end
  end

  // Checker next-state: breaks on blank/bad frames, checks numbers in TRACK.
  always_comb begin
    state_next   = state;
    prev_next    = prev;
    cur_next     = cur;
    locked_next  = locked;
    seq_ok_next  = 1'b0;
    seq_err_next = 1'b0;
    if (bad_frame || blank_evt) begin
      state_next  = SEEK;
      locked_next = 1'b0;
    end else if (value_valid) begin
      case (state)
        SEEK: begin
          cur_next   = value;
          state_next = ONE;
        end
        ONE: begin
          prev_next  = cur;
          cur_next   = value;
          state_next = TRACK;
        end
        TRACK: begin
          if (SUM_W'(value) == expected_c) begin
            seq_ok_next = 1'b1;
            locked_next = 1'b1;
            prev_next   = cur;
            cur_next    = value;
          end else begin
            seq_err_next = 1'b1;
            locked_next  = 1'b0;
            cur_next     = value;
            state_next   = ONE;
          end
        end
        default: state_next = SEEK;
      endcase
    end
  end

  // Saturating self-test counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_count <= '0;
      err_count   <= '0;
    end else begin
      if (seq_ok && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
      if ((seq_err || bad_frame) && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fibonacci_display_monitor.sv
// Self-checking bench for fibonacci_display_monitor with a frame-level model.
module tb_fibonacci_display_monitor;

  localparam int unsigned S  = 4;
  localparam int unsigned CW = 8;
  localparam logic [6:0] DASH = 7'b0111111;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    hex0 = '0, hex1 = '0, hex2 = '0;
  logic [9:0]    value;
  logic          value_valid, seq_ok, seq_err, bad_frame, locked;
  logic [CW-1:0] match_count, err_count;

  int checks = 0;
  int errors = 0;

  fibonacci_display_monitor #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .hex0(hex0), .hex1(hex1), .hex2(hex2),
    .value(value), .value_valid(value_valid), .seq_ok(seq_ok), .seq_err(seq_err),
    .bad_frame(bad_frame), .locked(locked), .match_count(match_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- monitor ----------------
  int mon_vals[$];
  int mon_ok, mon_err, mon_bad;
  bit mon_clash;

  always @(negedge clk) begin
    if (reset) begin
      mon_vals.delete();
      mon_ok = 0; mon_err = 0; mon_bad = 0; mon_clash = 0;
    end else begin
      if (value_valid) mon_vals.push_back(int'(value));
      if (seq_ok) mon_ok++;
      if (seq_err) mon_err++;
      if (bad_frame) mon_bad++;
      if (seq_err && bad_frame) mon_clash = 1;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [20:0] enc(input int v);
    return {seg_of(v / 100), seg_of((v / 10) % 10), seg_of(v % 10)};
  endfunction

  function automatic int dig_of(input logic [6:0] p);
    for (int d = 0; d < 10; d++) if (seg_of(d) == p) return d;
    if (p == DASH) return 10;
    return -1;
  endfunction

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  bit          m_acc;
  logic [20:0] m_last;
  int          m_hist[$];
  bit          m_locked;
  int          exp_vals[$];
  int          exp_ok, exp_err, exp_bad;

  task automatic model_reset();
    m_acc = 0; m_last = '0; m_hist.delete(); m_locked = 0;
    exp_vals.delete(); exp_ok = 0; exp_err = 0; exp_bad = 0;
  endtask

  // A frame shown for 'hold' cycles: accepted only if held past the debounce
  // window and not a repeat of the last accepted pattern.
  task automatic model_frame(input logic [20:0] pat, input int hold);
    int d0, d1, d2, v, p, c, e;
    if (hold < int'(S) + 1) return;
    if (m_acc && pat == m_last) return;
    m_acc = 1; m_last = pat;
    d0 = dig_of(pat[6:0]); d1 = dig_of(pat[13:7]); d2 = dig_of(pat[20:14]);
    if (d0 >= 0 && d0 < 10 && d1 >= 0 && d1 < 10 && d2 >= 0 && d2 < 10) begin
      v = d2 * 100 + d1 * 10 + d0;
      exp_vals.push_back(v);
      if (m_hist.size() >= 2) begin
        p = m_hist[0]; c = m_hist[1];
        e = (p == 0 && c == 1) ? 2 : p + c;
        m_hist.delete();
        if (v == e) begin
          exp_ok++; m_locked = 1;
          m_hist.push_back(c); m_hist.push_back(v);
        end else begin
          exp_err++; m_locked = 0;
          m_hist.push_back(v);
        end
      end else begin
        m_hist.push_back(v);
      end
    end else if ((d0 == 10 && d1 == 10 && d2 == 10) || pat == 21'h1FFFFF) begin
      m_hist.delete(); m_locked = 0;
    end else begin
      exp_bad++; m_locked = 0; m_hist.delete();
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic show(input logic [20:0] pat, input int hold);
    model_frame(pat, hold);
    {hex2, hex1, hex0} = pat;
    repeat (hold) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    {hex2, hex1, hex0} = '0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({value, value_valid, seq_ok, seq_err, bad_frame, locked, match_count, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got value=%0d vv=%0b ok=%0b err=%0b bad=%0b lk=%0b mc=%0d ec=%0d required all 0",
               value, value_valid, seq_ok, seq_err, bad_frame, locked, match_count, err_count);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checks++;
      if (value_valid !== 1'(k == 6)) begin
        errors++;
        $display("FAIL reset_latency E%0d: value_valid=%0b required %0b", k, value_valid, k == 6);
      end
      if (k == 6) begin
        checks++;
        if (value !== 10'd888) begin
          errors++;
          $display("FAIL reset_value: got %0d required 888", value);
        end
      end
    end
  endtask

  task automatic test_fib_sequence();
    int fib[13] = '{0, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      show(enc(fib[i]), 10);
      if (fib[i] == 1 || fib[i] == 2) begin
        checks++;
        if (locked !== 1'(fib[i] == 2)) begin
          errors++;
          $display("FAIL fib_locked_after_%0d: got %0b required %0b", fib[i], locked, fib[i] == 2);
        end
      end
    end
    drain();
    checks++;
    if (mon_vals.size() != 13) begin
      errors++;
      $display("FAIL fib_value_count: got %0d required 13", mon_vals.size());
    end
    for (int i = 0; i < 13 && i < mon_vals.size(); i++) begin
      checks++;
      if (mon_vals[i] != fib[i]) begin
        errors++;
        $display("FAIL fib_value[%0d]: got %0d required %0d", i, mon_vals[i], fib[i]);
      end
    end
    checks++;
    if (mon_ok != 11 || match_count !== 8'd11) begin
      errors++;
      $display("FAIL fib_matches: pulses=%0d count=%0d required 11", mon_ok, match_count);
    end
    checks++;
    if (err_count !== 8'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL fib_final: err_count=%0d locked=%0b required 0 and 1", err_count, locked);
    end
  endtask

  task automatic test_glitch();
    int fib[10] = '{0, 1, 2, 3, 5, 8, 13, 21, 34, 55};
    int n;
    logic [CW-1:0] mc, ec;
    do_reset();
    foreach (fib[i]) show(enc(fib[i]), 10);
    drain();
    n = mon_vals.size(); mc = match_count; ec = err_count;
    show(enc(89), int'(S) - 1);
    show(enc(55), 10);
    drain();
    checks++;
    if (mon_vals.size() != n) begin
      errors++;
      $display("FAIL glitch_values: got %0d pulses required %0d", mon_vals.size(), n);
    end
    checks++;
    if (match_count !== mc || err_count !== ec) begin
      errors++;
      $display("FAIL glitch_counters: mc=%0d ec=%0d required %0d %0d", match_count, err_count, mc, ec);
    end
  endtask

  task automatic test_mismatch_recovery();
    do_reset();
    show(enc(3), 10); show(enc(5), 10); show(enc(8), 10); show(enc(20), 10);
    #1;
    checks++;
    if (mon_err != 1 || err_count !== 8'd1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_err: pulses=%0d err_count=%0d locked=%0b required 1 1 0", mon_err, err_count, locked);
    end
    show(enc(28), 10);
    #1;
    checks++;
    if (mon_ok != 1 || mon_err != 1) begin
      errors++;
      $display("FAIL mismatch_no_check: ok=%0d err=%0d required 1 1", mon_ok, mon_err);
    end
    show(enc(48), 10);
    #1;
    checks++;
    if (mon_ok != 2 || locked !== 1'b1 || match_count !== 8'd2) begin
      errors++;
      $display("FAIL mismatch_relock: ok=%0d locked=%0b mc=%0d required 2 1 2", mon_ok, locked, match_count);
    end
  endtask

  task automatic test_bad_frame();
    logic [20:0] pat;
    do_reset();
    pat = enc(503);
    pat[13:7] = 7'b1111111;
    show(pat, 10);
    #1;
    checks++;
    if (mon_bad != 1 || err_count !== 8'd1 || mon_vals.size() != 0) begin
      errors++;
      $display("FAIL bad_frame: bad=%0d err_count=%0d values=%0d required 1 1 0", mon_bad, err_count, mon_vals.size());
    end
    show(enc(0), 10); show(enc(1), 10);
    drain();
    checks++;
    if (mon_ok != 0 || mon_err != 0 || mon_vals.size() != 2) begin
      errors++;
      $display("FAIL bad_then_seek: ok=%0d err=%0d values=%0d required 0 0 2", mon_ok, mon_err, mon_vals.size());
    end
  endtask

  task automatic test_blank_and_reset_abort();
    int fib[13] = '{0, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    do_reset();
    foreach (fib[i]) show(enc(fib[i]), 8);
    drain();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL blank_pre_locked: got %0b required 1", locked);
    end
    show({DASH, DASH, DASH}, 10);
    #1;
    checks++;
    if (locked !== 1'b0 || mon_err != 0 || mon_bad != 0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL blank_frame: locked=%0b err=%0d bad=%0d ec=%0d required 0 0 0 0", locked, mon_err, mon_bad, err_count);
    end
    show(enc(7), 3);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checks++;
      if (value_valid !== 1'(k == 6) || (k == 6 && value !== 10'd7)) begin
        errors++;
        $display("FAIL abort_latency E%0d: value_valid=%0b value=%0d required %0b 7", k, value_valid, value, k == 6);
      end
    end
    #1;
    checks++;
    if (mon_ok + mon_err + mon_bad != 0 || mon_vals.size() != 1) begin
      errors++;
      $display("FAIL abort_pulses: ok=%0d err=%0d bad=%0d values=%0d required 0 0 0 1", mon_ok, mon_err, mon_bad, mon_vals.size());
    end
  endtask

  task automatic test_random();
    logic [20:0] cur_pat, pat;
    logic [6:0]  ill;
    int hold, r, v, p, c, sel;
    do_reset();
    show(enc(1), 8);
    cur_pat = enc(1);
    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 99));
      hold = int'($urandom_range(S + 1, S + 8));
      if (r < 55) begin
        if (m_hist.size() >= 2) begin
          p = m_hist[0]; c = m_hist[1];
          v = (p == 0 && c == 1) ? 2 : p + c;
        end else begin
          v = int'($urandom_range(0, 20));
        end
        if (v > 999) v = int'($urandom_range(0, 999));
        pat = enc(v);
      end else if (r < 72) begin
        pat = enc(int'($urandom_range(0, 999)));
      end else if (r < 80) begin
        pat = r[0] ? {DASH, DASH, DASH} : 21'h1FFFFF;
      end else if (r < 90) begin
        pat = enc(int'($urandom_range(0, 999)));
        sel = int'($urandom_range(0, 2));
        ill = (r % 3 == 0) ? 7'b0000001 : ((r % 3 == 1) ? 7'b1010101 : 7'b1111111);
        if (sel == 0) pat[6:0] = ill;
        else if (sel == 1) pat[13:7] = ill;
        else pat[20:14] = ill;
      end else begin
        pat = enc(int'($urandom_range(0, 999)));
        hold = int'($urandom_range(1, S));
      end
      if (pat == cur_pat) continue;
      show(pat, hold);
      cur_pat = pat;
    end
    drain();
    checks++;
    if (mon_vals.size() != exp_vals.size()) begin
      errors++;
      $display("FAIL random_value_count: got %0d required %0d", mon_vals.size(), exp_vals.size());
    end
    for (int i = 0; i < exp_vals.size() && i < mon_vals.size(); i++) begin
      checks++;
      if (mon_vals[i] != exp_vals[i]) begin
        errors++;
        $display("FAIL random_value[%0d]: got %0d required %0d", i, mon_vals[i], exp_vals[i]);
      end
    end
    checks++;
    if (mon_ok != exp_ok || mon_err != exp_err || mon_bad != exp_bad) begin
      errors++;
      $display("FAIL random_pulses: ok=%0d err=%0d bad=%0d required %0d %0d %0d",
               mon_ok, mon_err, mon_bad, exp_ok, exp_err, exp_bad);
    end
    checks++;
    if (match_count !== 8'(sat(exp_ok)) || err_count !== 8'(sat(exp_err + exp_bad))) begin
      errors++;
      $display("FAIL random_counters: mc=%0d ec=%0d required %0d %0d",
               match_count, err_count, sat(exp_ok), sat(exp_err + exp_bad));
    end
    checks++;
    if (locked !== m_locked) begin
      errors++;
      $display("FAIL random_locked: got %0b required %0b", locked, m_locked);
    end
    checks++;
    if (mon_clash) begin
      errors++;
      $display("FAIL random_err_bad_same_cycle: got 1 required 0");
    end
  endtask

  task automatic test_err_saturation();
    logic [20:0] pa, pb;
    do_reset();
    pa = enc(5); pa[13:7] = 7'b0000001;
    pb = enc(6); pb[13:7] = 7'b0000001;
    for (int i = 0; i < 270; i++) show(i[0] ? pb : pa, int'(S) + 1);
    drain();
    checks++;
    if (mon_bad != exp_bad || mon_bad != 270) begin
      errors++;
      $display("FAIL sat_bad_pulses: got %0d required 270", mon_bad);
    end
    checks++;
    if (err_count !== 8'(sat(exp_bad)) || err_count !== 8'hFF) begin
      errors++;
      $display("FAIL sat_err_count: got %0d required 255", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_fib_sequence();
    test_glitch();
    test_mismatch_recovery();
    test_bad_frame();
    test_blank_and_reset_abort();
    test_random();
    test_err_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
